// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundles the fetch request, MEM-stage request, read response and
//             single-port memory signals seen by mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ISIZE = 16,
  parameter int DSIZE = 16
);
  // Fetch-stage request
  logic             i_req;
  logic [ISIZE-1:0] i_addr;
  logic             i_gnt;
  // MEM-stage request
  logic             d_req;
  logic             d_we;
  logic [ISIZE-1:0] d_addr;
  logic [DSIZE-1:0] d_wdata;
  logic             d_gnt;
  // Read response
  logic             rvalid;
  logic             rvalid_id;
  logic [DSIZE-1:0] rdata;
  // Memory port
  logic             m_en;
  logic             m_we;
  logic [ISIZE-1:0] m_addr;
  logic [DSIZE-1:0] m_wdata;
  logic [DSIZE-1:0] m_rdata;
  // Pipeline back-pressure to fetch
  logic             if_stall;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, d_gnt, rvalid, rvalid_id, rdata,
           m_en, m_we, m_addr, m_wdata, if_stall
  );

  // Requesters and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, d_gnt, rvalid, rvalid_id, rdata,
           m_en, m_we, m_addr, m_wdata, if_stall
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-cycle memory port between the fetch stage and
//             the MEM stage. MEM wins by default; fetch is forced through after
//             STARVE_MAX consecutive denials. Read data returns one cycle after
//             the grant, tagged with its owner.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ISIZE      = 16,
  parameter int DSIZE      = 16,
  parameter int STARVE_MAX = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,   // asynchronous, active-low
  mem_port_arbiter_if.slave  bus
);

  // Counter wide enough to hold STARVE_MAX; at least one bit so STARVE_MAX=0 is legal
  localparam int              CNT_W        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_PEND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             r_rvalid_id;

  logic             w_starved;
  logic             w_i_gnt;
  logic             w_d_gnt;
  logic             w_rd_gnt;
  logic             w_m_en;
  logic             w_m_we;
  logic [ISIZE-1:0] w_m_addr;
  logic [DSIZE-1:0] w_m_wdata;

  // Grant decision: MEM first unless fetch has hit its denial limit; nothing granted in reset
  always_comb begin
    w_starved = bus.i_req && (r_starve_cnt == STARVE_LIMIT);
    w_i_gnt   = 1'b0;
    w_d_gnt   = 1'b0;
    if (rst) begin
      if (w_starved) begin
        w_i_gnt = 1'b1;
      end else if (bus.d_req) begin
        w_d_gnt = 1'b1;
      end else if (bus.i_req) begin
        w_i_gnt = 1'b1;
      end
    end
  end

  // Steer the winner onto the memory port; everything idles at zero otherwise
  always_comb begin
    w_m_en    = w_i_gnt | w_d_gnt;
    w_m_we    = 1'b0;
    w_m_addr  = '0;
    w_m_wdata = '0;
    if (w_d_gnt) begin
      w_m_we    = bus.d_we;
      w_m_addr  = bus.d_addr;
      w_m_wdata = bus.d_wdata;
    end else if (w_i_gnt) begin
      w_m_addr  = bus.i_addr;
    end
  end

  // Denial counter: counts denied fetch cycles, saturates at the limit, clears otherwise
  always_comb begin
    w_starve_nxt = '0;
    if (bus.i_req && !w_i_gnt) begin
      if (r_starve_cnt == STARVE_LIMIT) begin
        w_starve_nxt = r_starve_cnt;
      end else begin
        w_starve_nxt = r_starve_cnt + CNT_W'(1);
      end
    end
  end

  // Response FSM next state: a read granted now is answered next cycle
  always_comb begin
    w_rd_gnt    = w_i_gnt | (w_d_gnt & ~bus.d_we);
    w_state_nxt = IDLE;
    if (w_rd_gnt) begin
      w_state_nxt = RD_PEND;
    end
  end

  // State, denial count and read owner; reset drops any pending read at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_rvalid_id  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_rd_gnt) begin
        r_rvalid_id <= w_d_gnt;
      end
    end
  end

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.m_en      = w_m_en;
  assign bus.m_we      = w_m_we;
  assign bus.m_addr    = w_m_addr;
  assign bus.m_wdata   = w_m_wdata;
  // Fetch must hold its PC whenever it asks and loses; forced low during reset
  assign bus.if_stall  = rst & bus.i_req & ~w_i_gnt;
  assign bus.rvalid    = (r_state == RD_PEND);
  assign bus.rvalid_id = r_rvalid_id;
  assign bus.rdata     = (r_state == RD_PEND) ? bus.m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed scenarios plus randomized traffic for mem_port_arbiter,
//             compared cycle by cycle against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ISIZE      = 16;
  localparam int DSIZE      = 16;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ISIZE(ISIZE), .DSIZE(DSIZE)) bus ();

  mem_port_arbiter #(
    .ISIZE      (ISIZE),
    .DSIZE      (DSIZE),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Preset contents of the 256-word memory (indexed by low address byte)
  function automatic logic [15:0] mem_init(input logic [7:0] a);
    if (a == 8'h10) return 16'hA5A5;
    return {a, ~a};
  endfunction

  // Behavioural single-port memory: read data appears one cycle after the access
  logic [15:0] mem [0:255];
  bit          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(8'(i));
      mem_ready <= 1'b1;
    end else if (bus.m_en && bus.m_we) begin
      mem[bus.m_addr[7:0]] <= bus.m_wdata;
    end
    if (bus.m_en && !bus.m_we) begin
      bus.m_rdata <= mem_ready ? mem[bus.m_addr[7:0]] : mem_init(bus.m_addr[7:0]);
    end
  end

  // Reference model state
  typedef struct {
    bit          id;
    logic [15:0] data;
  } resp_t;

  logic [15:0] ref_mem [0:255];
  resp_t       exp_q[$];
  int          starve;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle: drive requests, check every output against the model, advance the model
  task automatic step(input bit ireq, input logic [15:0] iaddr,
                      input bit dreq, input bit dwe,
                      input logic [15:0] daddr, input logic [15:0] dwdata,
                      output bit ei, output bit ed);
    resp_t r;
    @(posedge clk);
    #1;
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
    #3;
    ei = ireq && (!dreq || starve >= STARVE_MAX);
    ed = dreq && !ei;
    check("i_gnt",    64'(bus.i_gnt),    64'(ei));
    check("d_gnt",    64'(bus.d_gnt),    64'(ed));
    check("if_stall", 64'(bus.if_stall), 64'(ireq && !ei));
    check("m_en",     64'(bus.m_en),     64'(ei || ed));
    check("m_we",     64'(bus.m_we),     64'(ed && dwe));
    check("m_addr",   64'(bus.m_addr),   ed ? 64'(daddr) : (ei ? 64'(iaddr) : 64'd0));
    check("m_wdata",  64'(bus.m_wdata),  ed ? 64'(dwdata) : 64'd0);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check("rvalid",    64'(bus.rvalid),    64'd1);
      check("rvalid_id", 64'(bus.rvalid_id), 64'(r.id));
      check("rdata",     64'(bus.rdata),     64'(r.data));
    end else begin
      check("rvalid_idle", 64'(bus.rvalid), 64'd0);
      check("rdata_idle",  64'(bus.rdata),  64'd0);
    end
    if (ireq && !ei) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    else             starve = 0;
    if (ei)               exp_q.push_back('{1'b0, ref_mem[iaddr[7:0]]});
    else if (ed && !dwe)  exp_q.push_back('{1'b1, ref_mem[daddr[7:0]]});
    else if (ed && dwe)   ref_mem[daddr[7:0]] = dwdata;
  endtask

  task automatic idle_step();
    bit gi, gd;
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rvalid"},    64'(bus.rvalid),    64'd0);
    check({tag, "_rvalid_id"}, 64'(bus.rvalid_id), 64'd0);
    check({tag, "_rdata"},     64'(bus.rdata),     64'd0);
    check({tag, "_i_gnt"},     64'(bus.i_gnt),     64'd0);
    check({tag, "_d_gnt"},     64'(bus.d_gnt),     64'd0);
    check({tag, "_m_en"},      64'(bus.m_en),      64'd0);
    check({tag, "_m_we"},      64'(bus.m_we),      64'd0);
    check({tag, "_if_stall"},  64'(bus.if_stall),  64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          gi, gd;
    bit          hold_i, hold_d, hold_we;
    logic [15:0] hi_addr, hd_addr, hd_wdata;
    logic [4:0]  starve_pat;

    n_checks = 0;
    n_pass   = 0;
    starve   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));

    // Requests asserted during reset must not leak through
    bus.i_req   = 1'b1;
    bus.i_addr  = 16'h0033;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0044;
    bus.d_wdata = 16'hBEEF;
    #23;
    check_reset_outputs("por");
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    #4 rst = 1'b1;

    // Fetch read returning A5A5
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
    idle_step();
    check("fetch_rd_rdata", 64'(bus.rdata), 64'hA5A5);

    // Simultaneous requests: MEM write wins, fetch stalls, no response follows
    step(1'b1, 16'h0111, 1'b1, 1'b1, 16'h0200, 16'h1234, gi, gd);
    check("simul_if_stall", 64'(bus.if_stall), 64'd1);
    idle_step();

    // Starvation: d_gnt, d_gnt, d_gnt, i_gnt, d_gnt
    starve_pat = 5'b10111;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0030, 16'h0, gi, gd);
      check("starve_seq_d_gnt", 64'(bus.d_gnt), 64'(starve_pat[k]));
    end
    idle_step();
    idle_step();

    // Back-to-back reads: MEM then fetch
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, gi, gd);
    step(1'b1, 16'h0041, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
    check("b2b_first_id", 64'(bus.rvalid_id), 64'd1);
    idle_step();
    check("b2b_second_id", 64'(bus.rvalid_id), 64'd0);
    idle_step();

    // Async reset halfway through the response cycle of a MEM read
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, gi, gd);
    @(posedge clk);
    #1;
    bus.d_req  = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0077;
    #1;
    check("rst_pre_rvalid", 64'(bus.rvalid), 64'd1);
    void'(exp_q.pop_front());
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    starve = 0;
    bus.i_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    // First cycle after release: grant possible, dropped read not replayed
    step(1'b1, 16'h0012, 1'b0, 1'b0, 16'h0, 16'h0, gi, gd);
    idle_step();

    // Randomized traffic; a denied requester holds its request and address
    hold_i = 1'b0;
    hold_d = 1'b0;
    hold_we = 1'b0;
    hi_addr = '0;
    hd_addr = '0;
    hd_wdata = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold_i) begin
        hold_i  = ($urandom_range(0, 99) < 60);
        hi_addr = 16'($urandom);
      end
      if (!hold_d) begin
        hold_d   = ($urandom_range(0, 99) < 55);
        hold_we  = ($urandom_range(0, 1) == 1);
        hd_addr  = 16'($urandom);
        hd_wdata = 16'($urandom);
      end
      step(hold_i, hi_addr, hold_d, hold_we, hd_addr, hd_wdata, gi, gd);
      if (gi) hold_i = 1'b0;
      if (gd) hold_d = 1'b0;
    end
    idle_step();
    idle_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
